// File: rtl/mem_stage.sv
// Pipeline memory stage: branch resolution, data-memory request/ack handshake
// with a bounded wait, and the MEM/WB pipeline register.
module mem_stage #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        i_clk,
   input  logic        i_rst,

   input  logic        i_con_mem_branch,
   input  logic        i_con_mem_memread,
   input  logic        i_con_mem_memwrite,
   input  logic        i_con_wb_memtoreg,
   input  logic        i_con_wb_regwrite,
   input  logic [31:0] i_data_AddRst,
   input  logic        i_con_Zero,
   input  logic [31:0] i_data_ALU_Rst,
   input  logic [31:0] i_data_rt,
   input  logic [4:0]  i_addr_MuxRst,

   output logic        o_con_PCSrc,
   output logic [31:0] o_addr_PCBranch,
   output logic        o_con_stall,

   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,

   output logic        o_con_wb_regwrite,
   output logic        o_con_wb_memtoreg,
   output logic [31:0] o_data_ReadData,
   output logic [31:0] o_data_ALU_Rst,
   output logic [4:0]  o_addr_WriteReg,

   output logic        o_err_align,
   output logic        o_err_timeout
);

   // state | meaning
   // IDLE  | no access outstanding; MEM/WB follows EX/MEM on non-stall cycles
   // BUSY  | data-memory request outstanding, waiting for ack or timeout
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q,    state_d;
   logic [7:0]  cnt_q,      cnt_d;
   logic        req_q,      req_d;
   logic        we_q,       we_d;
   logic [31:0] addr_q,     addr_d;
   logic [31:0] wdata_q,    wdata_d;
   logic        regwrite_q, regwrite_d;
   logic        memtoreg_q, memtoreg_d;
   logic [31:0] rdata_q,    rdata_d;
   logic [31:0] alu_q,      alu_d;
   logic [4:0]  wreg_q,     wreg_d;
   logic        err_align_q,   err_align_d;
   logic        err_timeout_q, err_timeout_d;

   logic mem_op;
   logic aligned;
   logic timeout_hit;
   logic stall;

   assign mem_op      = i_con_mem_memread | i_con_mem_memwrite;
   assign aligned     = (i_data_ALU_Rst[1:0] == 2'b00);
   assign timeout_hit = (cnt_q == CNT_LAST);

   assign o_con_PCSrc     = i_con_mem_branch & i_con_Zero;
   assign o_addr_PCBranch = i_data_AddRst;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      req_d         = req_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      err_timeout_d = err_timeout_q;
      err_align_d   = 1'b0;
      stall         = 1'b0;
      // MEM/WB falls back to a bubble unless an instruction retires this cycle
      regwrite_d    = 1'b0;
      memtoreg_d    = 1'b0;
      rdata_d       = 32'h0;
      alu_d         = 32'h0;
      wreg_d        = 5'h0;

      if (state_q == ST_IDLE) begin
         if (!mem_op) begin
            regwrite_d = i_con_wb_regwrite;
            memtoreg_d = i_con_wb_memtoreg;
            alu_d      = i_data_ALU_Rst;
            wreg_d     = i_addr_MuxRst;
         end else if (aligned) begin
            stall   = 1'b1;
            state_d = ST_BUSY;
            cnt_d   = 8'h0;
            req_d   = 1'b1;
            we_d    = i_con_mem_memwrite;
            addr_d  = i_data_ALU_Rst;
            wdata_d = i_data_rt;
         end else begin
            err_align_d = 1'b1;
         end
      end else begin
         if (i_dmem_ack) begin
            state_d    = ST_IDLE;
            req_d      = 1'b0;
            regwrite_d = i_con_wb_regwrite;
            memtoreg_d = i_con_wb_memtoreg;
            alu_d      = i_data_ALU_Rst;
            wreg_d     = i_addr_MuxRst;
            rdata_d    = i_con_mem_memwrite ? 32'h0 : i_dmem_rdata;
         end else if (timeout_hit) begin
            state_d       = ST_IDLE;
            req_d         = 1'b0;
            err_timeout_d = 1'b1;
         end else begin
            stall = 1'b1;
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 8'h0;
         req_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= 32'h0;
         wdata_q       <= 32'h0;
         regwrite_q    <= 1'b0;
         memtoreg_q    <= 1'b0;
         rdata_q       <= 32'h0;
         alu_q         <= 32'h0;
         wreg_q        <= 5'h0;
         err_align_q   <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         req_q         <= req_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         regwrite_q    <= regwrite_d;
         memtoreg_q    <= memtoreg_d;
         rdata_q       <= rdata_d;
         alu_q         <= alu_d;
         wreg_q        <= wreg_d;
         err_align_q   <= err_align_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign o_con_stall       = stall;
   assign o_dmem_req        = req_q;
   assign o_dmem_we         = we_q;
   assign o_dmem_addr       = addr_q;
   assign o_dmem_wdata      = wdata_q;
   assign o_con_wb_regwrite = regwrite_q;
   assign o_con_wb_memtoreg = memtoreg_q;
   assign o_data_ReadData   = rdata_q;
   assign o_data_ALU_Rst    = alu_q;
   assign o_addr_WriteReg   = wreg_q;
   assign o_err_align       = err_align_q;
   assign o_err_timeout     = err_timeout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random EX/MEM traffic with a simple memory
// responder, expected MEM/WB results and requests queued and checked by a monitor.
module tb_mem_stage;

   localparam int TO = 4;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_con_mem_branch, i_con_mem_memread, i_con_mem_memwrite;
   logic        i_con_wb_memtoreg, i_con_wb_regwrite, i_con_Zero;
   logic [31:0] i_data_AddRst, i_data_ALU_Rst, i_data_rt;
   logic [4:0]  i_addr_MuxRst;
   logic        o_con_PCSrc, o_con_stall;
   logic [31:0] o_addr_PCBranch;
   logic        o_dmem_req, o_dmem_we;
   logic [31:0] o_dmem_addr, o_dmem_wdata;
   logic        i_dmem_ack;
   logic [31:0] i_dmem_rdata;
   logic        o_con_wb_regwrite, o_con_wb_memtoreg;
   logic [31:0] o_data_ReadData, o_data_ALU_Rst;
   logic [4:0]  o_addr_WriteReg;
   logic        o_err_align, o_err_timeout;

   mem_stage #(.TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_con_mem_branch(i_con_mem_branch), .i_con_mem_memread(i_con_mem_memread),
      .i_con_mem_memwrite(i_con_mem_memwrite), .i_con_wb_memtoreg(i_con_wb_memtoreg),
      .i_con_wb_regwrite(i_con_wb_regwrite), .i_data_AddRst(i_data_AddRst),
      .i_con_Zero(i_con_Zero), .i_data_ALU_Rst(i_data_ALU_Rst), .i_data_rt(i_data_rt),
      .i_addr_MuxRst(i_addr_MuxRst), .o_con_PCSrc(o_con_PCSrc),
      .o_addr_PCBranch(o_addr_PCBranch), .o_con_stall(o_con_stall),
      .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
      .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
      .o_con_wb_regwrite(o_con_wb_regwrite), .o_con_wb_memtoreg(o_con_wb_memtoreg),
      .o_data_ReadData(o_data_ReadData), .o_data_ALU_Rst(o_data_ALU_Rst),
      .o_addr_WriteReg(o_addr_WriteReg), .o_err_align(o_err_align),
      .o_err_timeout(o_err_timeout)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      bit          br, zr, rd, wr, rw, m2r;
      logic [31:0] add, alu, rt, rdata;
      logic [4:0]  wreg;
      int          lat;   // BUSY cycle in which memory acks; > TO means never
   } txn_t;

   typedef struct {
      bit          rw, m2r, align, to;
      logic [31:0] rdata, alu;
      logic [4:0]  wreg;
   } exp_t;

   typedef struct {
      logic [31:0] addr, wdata;
      bit          we;
      int          len;
   } req_t;

   exp_t sb[$];
   req_t rq[$];
   int   n_checks = 0;
   int   n_err = 0;
   bit   mon_en = 0;
   bit   model_to = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input txn_t t);
      i_con_mem_branch   = t.br;
      i_con_Zero         = t.zr;
      i_con_mem_memread  = t.rd;
      i_con_mem_memwrite = t.wr;
      i_con_wb_regwrite  = t.rw;
      i_con_wb_memtoreg  = t.m2r;
      i_data_AddRst      = t.add;
      i_data_ALU_Rst     = t.alu;
      i_data_rt          = t.rt;
      i_addr_MuxRst      = t.wreg;
   endtask

   // What the instruction leaves in MEM/WB once it retires.
   function automatic exp_t model(input txn_t t, input bit to_before);
      exp_t e;
      e = '{default: 0};
      e.to = to_before;
      if (!(t.rd || t.wr)) begin
         e.rw = t.rw; e.m2r = t.m2r; e.alu = t.alu; e.wreg = t.wreg;
      end else if (t.alu % 4 != 0) begin
         e.align = 1;
      end else if (t.lat > TO) begin
         e.to = 1;
      end else begin
         e.rw = t.rw; e.m2r = t.m2r; e.alu = t.alu; e.wreg = t.wreg;
         e.rdata = t.wr ? 32'h0 : t.rdata;
      end
      return e;
   endfunction

   task automatic issue(input txn_t t);
      exp_t e;
      req_t r;
      bit   mem_req, done;
      int   c, stalls, exp_stalls;
      drive(t);
      e = model(t, model_to);
      model_to = e.to;
      sb.push_back(e);
      mem_req = (t.rd || t.wr) && (t.alu % 4 == 0);
      exp_stalls = 0;
      if (mem_req) begin
         r.addr = t.alu; r.wdata = t.rt; r.we = t.wr;
         r.len = (t.lat > TO) ? TO : t.lat;
         exp_stalls = r.len;
         rq.push_back(r);
      end
      c = 0; stalls = 0; done = 0;
      while (!done && c <= TO + 2) begin
         if (mem_req && c >= 1) i_dmem_ack = (c == t.lat);
         else i_dmem_ack = 1'($urandom_range(0, 1));
         i_dmem_rdata = (mem_req && c == t.lat) ? t.rdata : $urandom();
         @(negedge i_clk);
         if (c == 0) begin
            check("pcsrc", o_con_PCSrc, t.br & t.zr);
            check("pcbranch", o_addr_PCBranch, t.add);
         end
         if (!o_con_stall) done = 1;
         else stalls++;
         @(posedge i_clk);
         #1;
         c++;
      end
      if (!done) begin
         n_checks++; n_err++;
         $display("FAIL stall_timeout: stall still high after %0d cycles", c);
      end
      check("stall_cycles", stalls, exp_stalls);
      i_dmem_ack = 0;
   endtask

   function automatic txn_t rand_txn(input bit allow_mem);
      txn_t t;
      t.br = 1'($urandom); t.zr = 1'($urandom);
      t.rd = allow_mem && ($urandom_range(0, 2) == 0);
      t.wr = allow_mem && ($urandom_range(0, 3) == 0);
      t.rw = 1'($urandom); t.m2r = 1'($urandom);
      t.add = $urandom(); t.rt = $urandom(); t.rdata = $urandom();
      t.alu = $urandom();
      if ($urandom_range(0, 3) != 0) t.alu = t.alu & 32'hFFFF_FFFC;
      t.wreg = 5'($urandom);
      t.lat = $urandom_range(1, TO + 2);
      return t;
   endfunction

   // Monitor: MEM/WB after an accepting edge must match the queued result,
   // after a stall edge it must be a bubble; requests are checked separately.
   initial begin
      bit   have_prev, prev_stall, prev_req;
      int   rlen;
      exp_t e;
      req_t r;
      have_prev = 0; prev_stall = 0; prev_req = 0; rlen = 0;
      r = '{default: 0};
      forever begin
         @(negedge i_clk);
         if (!mon_en) begin
            have_prev = 0; prev_req = 0;
            continue;
         end
         if (have_prev) begin
            if (!prev_stall) begin
               if (sb.size() == 0) begin
                  n_checks++; n_err++;
                  $display("FAIL sb_underflow: result with no expected entry at %0t", $time);
               end else begin
                  e = sb.pop_front();
                  check("wb_regwrite", o_con_wb_regwrite, e.rw);
                  check("wb_memtoreg", o_con_wb_memtoreg, e.m2r);
                  check("wb_readdata", o_data_ReadData, e.rdata);
                  check("wb_alu", o_data_ALU_Rst, e.alu);
                  check("wb_writereg", o_addr_WriteReg, e.wreg);
                  check("err_align", o_err_align, e.align);
                  check("err_timeout", o_err_timeout, e.to);
               end
            end else begin
               check("bubble_ctl", {o_con_wb_regwrite, o_con_wb_memtoreg, o_addr_WriteReg, o_err_align}, 0);
               check("bubble_rdata", o_data_ReadData, 0);
               check("bubble_alu", o_data_ALU_Rst, 0);
            end
         end
         prev_stall = o_con_stall;
         have_prev = 1;
         if (o_dmem_req) begin
            if (!prev_req) begin
               rlen = 0;
               if (rq.size() == 0) begin
                  n_checks++; n_err++;
                  $display("FAIL rq_underflow: unexpected request at %0t", $time);
                  r = '{default: 0};
               end else r = rq.pop_front();
            end
            check("req_addr", o_dmem_addr, r.addr);
            check("req_wdata", o_dmem_wdata, r.wdata);
            check("req_we", o_dmem_we, r.we);
            rlen++;
         end else if (prev_req) begin
            check("req_len", rlen, r.len);
         end
         prev_req = o_dmem_req;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t t;
      int   reqc, k;
      bit   done;
      t = '{default: 0};
      drive(t);
      i_dmem_ack = 0; i_dmem_rdata = 0;
      i_rst = 1;
      repeat (3) tick();
      check("rst_req", o_dmem_req, 0);
      check("rst_bus", {o_dmem_we, o_dmem_addr, o_dmem_wdata}, 0);
      check("rst_wb", {o_con_wb_regwrite, o_con_wb_memtoreg, o_addr_WriteReg, o_data_ALU_Rst}, 0);
      check("rst_err", {o_err_align, o_err_timeout}, 0);
      i_rst = 0;

      // branch resolution is purely combinational
      i_con_mem_branch = 1; i_con_Zero = 1; i_data_AddRst = 32'h40;
      #1;
      check("br_take", o_con_PCSrc, 1);
      check("br_target", o_addr_PCBranch, 32'h40);
      i_con_Zero = 0;
      #1;
      check("br_nottake", o_con_PCSrc, 0);
      i_con_mem_branch = 0;
      tick();

      mon_en = 1;
      for (int n = 0; n < 300; n++) issue(rand_txn(1));
      issue(rand_txn(0));
      issue(rand_txn(0));
      @(negedge i_clk);
      #1;
      mon_en = 0;
      check("sb_drained", sb.size(), 0);
      check("rq_drained", rq.size(), 0);
      tick();

      // load with no ack: request held TO cycles then abort, sticky error
      t = '{default: 0};
      t.rd = 1; t.m2r = 1; t.rw = 1; t.alu = 32'h200;
      drive(t);
      reqc = 0; k = 0; done = 0;
      while (!done && k < 20) begin
         @(negedge i_clk);
         if (o_dmem_req) reqc++;
         done = !o_con_stall;
         @(posedge i_clk);
         #1;
         k++;
      end
      check("to_req_cycles", reqc, TO);
      check("to_req_low", o_dmem_req, 0);
      check("to_sticky", o_err_timeout, 1);
      check("to_wb_bubble", o_con_wb_regwrite, 0);
      t = '{default: 0};
      t.rw = 1; t.alu = 32'h44; t.wreg = 5'd7;
      drive(t);
      tick();
      check("to_after_alu", o_data_ALU_Rst, 32'h44);
      check("to_still_set", o_err_timeout, 1);
      i_rst = 1;
      tick();
      check("to_cleared", o_err_timeout, 0);
      check("rst_wb_alu", o_data_ALU_Rst, 0);
      check("rst_wb_regwrite", o_con_wb_regwrite, 0);
      i_rst = 0;

      // reset in the middle of a store, then a late ack must be ignored
      t = '{default: 0};
      t.wr = 1; t.alu = 32'h300; t.rt = 32'hCAFE_F00D;
      drive(t);
      tick();
      tick();
      check("busy_req", o_dmem_req, 1);
      check("busy_we", o_dmem_we, 1);
      i_rst = 1;
      tick();
      check("rst_busy_req", o_dmem_req, 0);
      check("rst_busy_bus", {o_dmem_we, o_dmem_addr, o_dmem_wdata}, 0);
      i_rst = 0;
      t = '{default: 0};
      t.rw = 1; t.alu = 32'h10; t.wreg = 5'd5;
      drive(t);
      i_dmem_ack = 1; i_dmem_rdata = 32'hBAD0_BAD0;
      #1;
      check("alu_stall", o_con_stall, 0);
      tick();
      i_dmem_ack = 0;
      check("alu_regwrite", o_con_wb_regwrite, 1);
      check("alu_result", o_data_ALU_Rst, 32'h10);
      check("alu_wreg", o_addr_WriteReg, 5);
      check("alu_rdata", o_data_ReadData, 0);
      check("late_ack_req", o_dmem_req, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT, default 64 (legal 1-255), max BUSY cycles without i_dmem_ack before the access is aborted.
REQ-002 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_con_mem_branch, i_con_mem_memread, i_con_mem_memwrite, i_con_wb_memtoreg, i_con_wb_regwrite  in  1 each  EX/MEM control bits.
REQ-005 i_data_AddRst  in  32  branch target; i_con_Zero  in  1  ALU zero flag.
REQ-006 i_data_ALU_Rst  in  32  ALU result / memory byte address; i_data_rt  in  32  store data; i_addr_MuxRst  in  5  destination register.
REQ-007 o_con_PCSrc  out  1  take branch; o_addr_PCBranch  out  32  branch target.
REQ-008 o_con_stall  out  1  upstream holds EX/MEM inputs stable while 1.
REQ-009 o_dmem_req  out  1; o_dmem_we  out  1; o_dmem_addr  out  32; o_dmem_wdata  out  32  data-memory request bus.
REQ-010 i_dmem_ack  in  1  access complete; i_dmem_rdata  in  32  read data, valid with ack.
REQ-011 o_con_wb_regwrite, o_con_wb_memtoreg  out  1 each; o_data_ReadData  out  32; o_data_ALU_Rst  out  32; o_addr_WriteReg  out  5  MEM/WB register.
REQ-012 o_err_align  out  1  one-cycle pulse, misaligned access dropped; o_err_timeout  out  1  sticky, access aborted.

Function
REQ-013 o_con_PCSrc = i_con_mem_branch AND i_con_Zero, combinational; o_addr_PCBranch = i_data_AddRst, combinational; neither depends on FSM state.
REQ-014 Memory op = memread OR memwrite; both set means write (o_dmem_we=1, read data discarded, ReadData loaded 0).
REQ-015 FSM has two states, IDLE and BUSY; a BUSY-cycle counter, 8 bits, clears on entry to BUSY.
REQ-016 IDLE, no memory op: o_con_stall=0; next edge loads MEM/WB with regwrite, memtoreg, ALU_Rst, MuxRst, and ReadData=0 (1-cycle latency).
REQ-017 IDLE, memory op, i_data_ALU_Rst[1:0]=00: o_con_stall=1; next edge sets o_dmem_req=1, o_dmem_addr=ALU_Rst, o_dmem_wdata=rt, o_dmem_we=memwrite, state=BUSY, MEM/WB loads bubble.
REQ-018 IDLE, memory op, ALU_Rst[1:0]!=00: no request, o_con_stall=0, next edge MEM/WB bubble and o_err_align=1 for exactly one cycle.
REQ-019 Bubble = regwrite=0, memtoreg=0, ReadData=0, ALU_Rst=0, WriteReg=0.
REQ-020 BUSY: o_dmem_req, addr, wdata, we held constant; o_con_stall=1 except in the ack cycle and the timeout cycle.
REQ-021 BUSY with i_dmem_ack=1: o_con_stall=0 (combinational); next edge loads MEM/WB with input controls/ALU_Rst/MuxRst and ReadData = i_dmem_rdata for a read, 0 for a write; o_dmem_req=0; state=IDLE.
REQ-022 Minimum memory-op latency: 2 cycles (request edge, ack in first BUSY cycle); back-to-back memory ops start from IDLE with no extra gap.
REQ-023 BUSY without ack while counter = TIMEOUT-1: o_con_stall=0; next edge MEM/WB bubble, o_dmem_req=0, state=IDLE, o_err_timeout=1 (held until reset).
REQ-024 Ack arriving together with timeout condition: ack wins, no error.
REQ-025 i_dmem_ack in IDLE is ignored.
REQ-026 Non-bubble MEM/WB updates only on a non-stall cycle; during stall cycles MEM/WB holds bubble.

Reset
REQ-027 i_rst=1 at an edge: state=IDLE, counter=0, o_dmem_req=0, o_dmem_we=0, o_dmem_addr=0, o_dmem_wdata=0, all MEM/WB outputs 0, o_err_align=0, o_err_timeout=0.
REQ-028 Reset during BUSY abandons the access; a later i_dmem_ack is ignored; combinational outputs follow inputs during reset.

Verification
REQ-029 ALU op: regwrite=1, ALU_Rst=0x0000_0010, MuxRst=5 in IDLE -> stall=0, next cycle o_con_wb_regwrite=1, o_data_ALU_Rst=0x10, o_addr_WriteReg=5, ReadData=0.
REQ-030 Load addr 0x100, ack after 3 BUSY cycles with rdata 0xDEAD_BEEF -> req high 3 cycles, stall high 3 cycles, ReadData=0xDEADBEEF, memtoreg=1 after ack edge.
REQ-031 Store addr 0x104, rt=0x1234_5678, ack in first BUSY cycle -> o_dmem_we=1, wdata=0x12345678 for one cycle, WB regwrite=0.
REQ-032 Load addr 0x102 -> no req, o_err_align pulse 1 cycle, WB bubble, stall=0.
REQ-033 TIMEOUT=4, load with no ack -> req high 4 cycles then 0, o_err_timeout=1 sticky; i_rst clears it.
REQ-034 branch=1, Zero=1, AddRst=0x40 -> o_con_PCSrc=1, o_addr_PCBranch=0x40 same cycle; Zero=0 -> PCSrc=0.
